bcd_display_formatter: RTL and testbench

- Sequential binary-to-BCD converter that sits directly upstream of the seven-segment display controller.
- Takes an unsigned binary value from the core's display MMIO register and converts it with iterative double-dabble, one bit per cycle.
- Presents packed BCD, one digit per nibble, so the controller's hex digit decode shows the value in decimal.
- Holds the last result stable between conversions. Saturates values that do not fit in DIGITS decimal digits.

---
 rtl/display_pkg.sv | 21 ++
 rtl/bcd_digit_adjust.sv | 12 +
 rtl/bcd_display_formatter.sv | 101 ++++++++++
 tb/tb_bcd_display_formatter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the decimal display path.
// Holds the FSM encoding, digit type and the saturation-limit helper.
package display_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  typedef logic [3:0] bcd_digit_t;

  // 10^digits - 1, kept at 64 bits so any input width can compare against it.
  function automatic logic [63:0] dec_max(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more before the shift.
// Purely combinational; inputs are always valid BCD so the result fits in 4 bits.
module bcd_digit_adjust
  import display_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? bcd_digit_t'(i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bcd_display_formatter.sv
// Iterative binary-to-BCD converter, one bit per cycle; result WIDTH+1 cycles after accept.
// Accepts only in IDLE (no queueing); out_bcd/overflow are held until the next DONE.
module bcd_display_formatter
  import display_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_value,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                          out_valid,
  output logic                          overflow,
  output logic                          busy
);

  localparam int          CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int          ACC_W   = BCD_DIGIT_W * DIGITS;
  localparam logic [63:0] DEC_MAX = dec_max(DIGITS);
  // When 10^DIGITS-1 does not fit in WIDTH bits, no input can overflow.
  localparam bit              CAN_OVF = ((DEC_MAX >> WIDTH) == 64'd0);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(DEC_MAX);

  bcd_state_t         r_state;
  bcd_state_t         w_state_nxt;
  logic [WIDTH-1:0]   r_bin;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_adj;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_pend;
  logic [ACC_W-1:0]   r_out_bcd;
  logic               r_out_vld;
  logic               r_overflow;
  logic               w_accept;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign w_accept  = in_valid && (r_state == IDLE);
  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_bcd   = r_out_bcd;
  assign out_valid = r_out_vld;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == '0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin      <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_out_bcd  <= '0;
      r_overflow <= 1'b0;
      r_out_vld  <= 1'b0;
    end else begin
      r_out_vld <= (r_state == DONE);
      if (w_accept) begin
        r_bin      <= in_value;
        r_acc      <= '0;
        r_cnt      <= CNT_W'(WIDTH - 1);
        r_ovf_pend <= CAN_OVF && (in_value > MAX_W);
      end
      if (r_state == SHIFT) begin
        // Bits pushed past the top digit are dropped; saturation comes from r_ovf_pend.
        r_acc <= {w_adj[ACC_W-2:0], r_bin[WIDTH-1]};
        r_bin <= {r_bin[WIDTH-2:0], 1'b0};
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (r_state == DONE) begin
        r_out_bcd  <= r_ovf_pend ? {DIGITS{4'h9}} : r_acc;
        r_overflow <= r_ovf_pend;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Self-checking bench for bcd_display_formatter: vector table, corner sequences, random vs model.
module tb_bcd_display_formatter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [31:0] out_bcd;
  logic        out_valid;
  logic        overflow;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  bcd_display_formatter #(.WIDTH(32), .DIGITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .out_bcd   (out_bcd),
    .out_valid (out_valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] val;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  // Reference model: decimal digits by repeated division, saturating above 99999999.
  function automatic logic [31:0] model_bcd(input logic [31:0] v);
    longint unsigned x;
    logic [31:0]     r;
    x = longint'(v);
    if (x > 64'd99999999) return 32'h99999999;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input logic [31:0] v);
    return v > 32'd99999999;
  endfunction

  // Called at a negedge with in_valid/in_value already driven and in_ready high;
  // the next posedge is the accept edge. Returns at the negedge where out_valid is seen.
  task automatic wait_result(input string nm, input logic [31:0] exp_bcd,
                             input logic exp_ovf, input bit keep_valid);
    int          samples;
    int          low;
    bit          seen;
    bit          stable;
    logic [31:0] held;
    logic        held_ovf;
    held     = out_bcd;
    held_ovf = overflow;
    samples  = 0;
    low      = 0;
    seen     = 1'b0;
    stable   = 1'b1;
    while (!seen && samples < 100) begin
      @(negedge clk);
      samples++;
      if (keep_valid) in_value = $urandom;
      else begin
        in_valid = 1'b0;
        in_value = $urandom;
      end
      if (out_valid) seen = 1'b1;
      else begin
        if (!in_ready) low++;
        if (out_bcd !== held || overflow !== held_ovf) stable = 1'b0;
      end
    end
    if (!seen) chk({nm, "_timeout"}, 64'd0, 64'd1);
    chk({nm, "_bcd"}, out_bcd, exp_bcd);
    chk({nm, "_ovf"}, overflow, exp_ovf);
    chk({nm, "_latency"}, samples - 1, 33);
    chk({nm, "_ready_low"}, low, 33);
    chk({nm, "_ready_at_valid"}, in_ready, 1);
    chk({nm, "_hold"}, stable, 1);
  endtask

  task automatic run_conv(input string nm, input logic [31:0] v,
                          input logic [31:0] exp_bcd, input logic exp_ovf);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    in_valid = 1'b1;
    in_value = v;
    wait_result(nm, exp_bcd, exp_ovf, 1'b0);
    @(negedge clk);
    chk({nm, "_pulse"}, out_valid, 0);
  endtask

  int vld_cnt;

  initial begin
    tbl[0] = '{32'd0,          32'h00000000, 1'b0};
    tbl[1] = '{32'd12345678,   32'h12345678, 1'b0};
    tbl[2] = '{32'd90817,      32'h00090817, 1'b0};
    tbl[3] = '{32'd99999999,   32'h99999999, 1'b0};
    tbl[4] = '{32'd100000000,  32'h99999999, 1'b1};
    tbl[5] = '{32'hFFFFFFFF,   32'h99999999, 1'b1};
    tbl[6] = '{32'd9,          32'h00000009, 1'b0};
    tbl[7] = '{32'd10,         32'h00000010, 1'b0};
    tbl[8] = '{32'd5,          32'h00000005, 1'b0};
    tbl[9] = '{32'd80000000,   32'h80000000, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_bcd", out_bcd, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);

    for (int i = 0; i < 10; i++) begin
      run_conv($sformatf("vec%0d", i), tbl[i].val, tbl[i].bcd, tbl[i].ovf);
    end

    // in_valid held high with churning data: only the accept-edge value counts,
    // and the next value is taken on the out_valid cycle.
    in_valid = 1'b1;
    in_value = 32'd42;
    wait_result("hold42", 32'h00000042, 1'b0, 1'b1);
    in_value = 32'd77;
    wait_result("b2b77", 32'h00000077, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b77_pulse", out_valid, 0);

    // Reset during a conversion aborts it silently.
    run_conv("c777", 32'd777, 32'h00000777, 1'b0);
    in_valid = 1'b1;
    in_value = 32'd555;
    repeat (10) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_busy", busy, 1);
    chk("mid_hold", out_bcd, 32'h00000777);
    rst_n = 1'b0;
    #1;
    chk("arst_bcd", out_bcd, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    vld_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) vld_cnt++;
    end
    chk("arst_no_valid", vld_cnt, 0);
    run_conv("pi", 32'd31415926, 32'h31415926, 1'b0);

    for (int i = 0; i < 25; i++) begin
      logic [31:0] v;
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 999);
        1:       v = $urandom % 32'd100000000;
        2:       v = $urandom;
        default: v = 32'd99999990 + $urandom_range(0, 20);
      endcase
      run_conv($sformatf("rnd%0d", i), v, model_bcd(v), model_ovf(v));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
